// File: rtl/qam16_pkg.sv
// Shared 16-QAM constants: default levels, frame geometry, Gray codes and the
// receive FSM state encoding (also used by the modulator mapping table).
package qam16_pkg;

  localparam int AMP_DEFAULT      = 64;
  localparam int SYMS_DEFAULT     = 32;
  localparam int SAMPLE_W_DEFAULT = 9;
  localparam int FRAME_W          = 4 * SYMS_DEFAULT;

  // Gray mapping of the four amplitude levels, most negative first.
  localparam logic [1:0] G_M3 = 2'b00;
  localparam logic [1:0] G_M1 = 2'b01;
  localparam logic [1:0] G_P1 = 2'b11;
  localparam logic [1:0] G_P3 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

endpackage

// File: rtl/qam16_slicer.sv
// Combinational hard slicer for one axis: signed sample against +/-thr_i
// produces the 2-bit Gray code of the nearest 16-QAM level.
module qam16_slicer
  import qam16_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
  input  logic signed [SAMPLE_W-1:0] x_i,
  input  logic signed [SAMPLE_W:0]   thr_i,
  output logic        [1:0]          code_o
);

  // One extra bit keeps +thr and -thr representable for any legal sample width.
  logic signed [SAMPLE_W:0] x_ext;
  logic signed [SAMPLE_W:0] neg_thr;

  assign x_ext   = SAMPLE_W'(1) == 0 ? '0 : {x_i[SAMPLE_W-1], x_i};
  assign neg_thr = -thr_i;

  always_comb begin
    if (x_ext < neg_thr)    code_o = G_M3;
    else if (x_ext[SAMPLE_W]) code_o = G_M1;
    else if (x_ext < thr_i) code_o = G_P1;
    else                    code_o = G_P3;
  end

endmodule

// File: rtl/demod_16qam_rx.sv
// 16-QAM receive slicer and frame packer: slices I/Q samples to Gray symbols,
// packs SYMS symbols into one codeword and offers it on a valid/ready port.
module demod_16qam_rx
  import qam16_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int AMP      = AMP_DEFAULT,
  parameter int SYMS     = SYMS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic                       sof,
  input  logic signed [SAMPLE_W-1:0] i_in,
  input  logic signed [SAMPLE_W-1:0] q_in,
  output logic        [3:0]          sym_out,
  output logic                       sym_valid,
  output logic        [4*SYMS-1:0]   frame_out,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic                       overflow,
  output logic                       busy
);

  localparam int FW    = 4 * SYMS;
  localparam int CNT_W = $clog2(SYMS + 1);
  localparam logic signed [SAMPLE_W:0] THR = (SAMPLE_W + 1)'(2 * AMP);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SYMS - 1);

  logic [1:0] code_i, code_q;
  logic [3:0] sym;

  qam16_slicer #(.SAMPLE_W(SAMPLE_W)) u_slice_i (.x_i(i_in), .thr_i(THR), .code_o(code_i));
  qam16_slicer #(.SAMPLE_W(SAMPLE_W)) u_slice_q (.x_i(q_in), .thr_i(THR), .code_o(code_q));

  assign sym = {code_i, code_q};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [FW-1:0]    asm_q, asm_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic [3:0]       sym_q, sym_d;
  logic             symv_q, symv_d;
  logic             ovf_q, ovf_d;

  // Candidate assembly words: current partial frame with this symbol at its
  // slot, and a fresh frame holding only slot 0.
  logic [FW-1:0] asm_ins, asm_start;

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    asm_d     = asm_q;
    frame_d   = frame_q;
    sym_d     = sym_q;
    symv_d    = 1'b0;
    ovf_d     = ovf_q;

    asm_ins   = asm_q;
    asm_ins[FW-1-4*int'(count_q) -: 4] = sym;
    asm_start = '0;
    asm_start[FW-1 -: 4] = sym;

    unique case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          sym_d  = sym;
          symv_d = 1'b1;
          if (sof) begin
            asm_d   = asm_start;
            count_d = CNT_W'(1);
            state_d = ST_COLLECT;
          end
        end
      end

      ST_COLLECT: begin
        if (sample_valid) begin
          sym_d  = sym;
          symv_d = 1'b1;
          if (sof) begin
            asm_d   = asm_start;
            count_d = CNT_W'(1);
          end else if (count_q == LAST_SLOT) begin
            frame_d = asm_ins;
            count_d = '0;
            state_d = ST_FULL;
          end else begin
            asm_d   = asm_ins;
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      ST_FULL: begin
        // A sof arriving with frame_ready chains straight into the next frame.
        if (frame_ready && sample_valid && sof) begin
          sym_d   = sym;
          symv_d  = 1'b1;
          asm_d   = asm_start;
          count_d = CNT_W'(1);
          state_d = ST_COLLECT;
        end else begin
          if (sample_valid) ovf_d = 1'b1;
          if (frame_ready)  state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      asm_q   <= '0;
      frame_q <= '0;
      sym_q   <= '0;
      symv_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      asm_q   <= asm_d;
      frame_q <= frame_d;
      sym_q   <= sym_d;
      symv_q  <= symv_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sym_out     = sym_q;
  assign sym_valid   = symv_q;
  assign frame_out   = frame_q;
  assign frame_valid = (state_q == ST_FULL);
  assign overflow    = ovf_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_demod_16qam_rx.sv
// Self-checking bench for demod_16qam_rx: directed scenarios with random
// samples, compared every cycle against a queue-based behavioural model.
module tb_demod_16qam_rx;

  logic              clk = 1'b0;
  logic              reset;
  logic              sample_valid;
  logic              sof;
  logic signed [8:0] i_in;
  logic signed [8:0] q_in;
  logic [3:0]        sym_out;
  logic              sym_valid;
  logic [127:0]      frame_out;
  logic              frame_valid;
  logic              frame_ready;
  logic              overflow;
  logic              busy;

  always #5 clk = ~clk;

  demod_16qam_rx dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sof(sof),
    .i_in(i_in), .q_in(q_in), .sym_out(sym_out), .sym_valid(sym_valid),
    .frame_out(frame_out), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .overflow(overflow), .busy(busy)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Behavioural model: symbols collected in a queue, packed when 32 are held.
  bit           m_coll, m_full, m_ovf, m_sv;
  logic [3:0]   m_sym;
  logic [127:0] m_frame;
  logic [3:0]   m_syms[$];

  function automatic logic [1:0] ref_slice(input int x);
    int t;
    t = 2 * 64;
    if (x < -t)     return 2'b00;
    else if (x < 0) return 2'b01;
    else if (x < t) return 2'b11;
    else            return 2'b10;
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit rst, v, s, r, input int i, q);
    logic [3:0] sy;
    sy   = {ref_slice(i), ref_slice(q)};
    m_sv = 1'b0;
    if (rst) begin
      m_coll = 0; m_full = 0; m_ovf = 0; m_sym = '0; m_frame = '0;
      m_syms.delete();
    end else if (m_full) begin
      if (r && v && s) begin
        m_sv = 1; m_sym = sy; m_full = 0; m_coll = 1;
        m_syms.delete(); m_syms.push_back(sy);
      end else begin
        if (v) m_ovf = 1;
        if (r) m_full = 0;
      end
    end else if (v) begin
      m_sv = 1; m_sym = sy;
      if (s) begin
        m_coll = 1; m_syms.delete(); m_syms.push_back(sy);
      end else if (m_coll) begin
        m_syms.push_back(sy);
      end
      if (m_syms.size() == 32) begin
        for (int k = 0; k < 32; k++) m_frame[127-4*k -: 4] = m_syms[k];
        m_full = 1; m_coll = 0; m_syms.delete();
      end
    end
  endtask

  task automatic step(input bit rst, v, s, r, input int i, q);
    reset        = rst;
    sample_valid = v;
    sof          = s;
    frame_ready  = r;
    i_in         = 9'(i);
    q_in         = 9'(q);
    @(posedge clk);
    #1;
    model_update(rst, v, s, r, i, q);
    check("sym_valid",   128'(sym_valid),   128'(m_sv));
    check("sym_out",     128'(sym_out),     128'(m_sym));
    check("frame_valid", 128'(frame_valid), 128'(m_full));
    check("frame_out",   frame_out,         m_frame);
    check("overflow",    128'(overflow),    128'(m_ovf));
    check("busy",        128'(busy),        128'(m_coll | m_full));
  endtask

  task automatic send(input bit s, input int i, q);
    step(1'b0, 1'b1, s, 1'b0, i, q);
  endtask

  task automatic idle_cycle(input bit r);
    step(1'b0, 1'b0, 1'b0, r, 0, 0);
  endtask

  int          bnd_val[7]  = '{0, 128, -128, 127, -129, 255, -256};
  logic [1:0]  bnd_exp[7]  = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00};
  logic [127:0] all9;
  logic [127:0] saved;
  int          ri, rq, rise_n;
  logic [3:0]  resync_sym;

  initial begin
    all9 = {32{4'h9}};

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    check("reset_frame_valid", 128'(frame_valid), 128'(0));
    check("reset_busy",        128'(busy),        128'(0));

    // Ideal frame: I=+3A, Q=-A throughout.
    for (int k = 0; k < 32; k++) begin
      send(k == 0, 192, -64);
      if (k == 30) check("ideal_fv_early", 128'(frame_valid), 128'(0));
    end
    check("ideal_sym",   128'(sym_out),     128'(4'b1001));
    check("ideal_fv",    128'(frame_valid), 128'(1));
    check("ideal_frame", frame_out,         all9);

    // Hold frame with ready low while extra samples arrive.
    for (int k = 0; k < 10; k++) begin
      if (k == 2 || k == 5 || k == 8) send(1'b0, rnd_sample(), rnd_sample());
      else idle_cycle(1'b0);
    end
    check("hold_frame",    frame_out,         all9);
    check("hold_overflow", 128'(overflow),    128'(1));
    idle_cycle(1'b1);
    check("release_fv",   128'(frame_valid), 128'(0));
    check("release_busy", 128'(busy),        128'(0));

    // Boundary slicing, sent in IDLE without sof.
    for (int k = 0; k < 7; k++) begin
      send(1'b0, bnd_val[k], bnd_val[k]);
      check($sformatf("bound_%0d", bnd_val[k]), 128'(sym_out), 128'({bnd_exp[k], bnd_exp[k]}));
    end
    check("bound_idle", 128'(busy), 128'(0));

    // Resync: sof at symbol 20 restarts the frame.
    for (int k = 0; k < 20; k++) send(k == 0, rnd_sample(), rnd_sample());
    ri = rnd_sample();
    rq = rnd_sample();
    resync_sym = {ref_slice(ri), ref_slice(rq)};
    send(1'b1, ri, rq);
    for (int k = 0; k < 31; k++) begin
      send(1'b0, rnd_sample(), rnd_sample());
      if (k == 11) check("resync_no_early", 128'(frame_valid), 128'(0));
    end
    check("resync_fv",   128'(frame_valid),      128'(1));
    check("resync_slot0", 128'(frame_out[127:124]), 128'(resync_sym));

    // Back-to-back: ready coincident with the next sof.
    saved  = frame_out;
    rise_n = 0;
    step(1'b0, 1'b1, 1'b1, 1'b1, rnd_sample(), rnd_sample());
    check("b2b_accept", 128'(sym_valid), 128'(1));
    for (int n = 2; n <= 40 && rise_n == 0; n++) begin
      send(1'b0, rnd_sample(), rnd_sample());
      if (frame_valid) rise_n = n;
    end
    check("b2b_latency", 128'(rise_n), 128'(32));
    idle_cycle(1'b1);

    // Reset mid-frame at symbol 15.
    for (int k = 0; k < 15; k++) send(k == 0, rnd_sample(), rnd_sample());
    step(1'b1, 1'b1, 1'b0, 1'b0, rnd_sample(), rnd_sample());
    check("midrst_frame", frame_out,      128'(0));
    check("midrst_ovf",   128'(overflow), 128'(0));
    check("midrst_sym",   128'(sym_out),  128'(0));
    for (int k = 0; k < 32; k++) send(1'b0, rnd_sample(), rnd_sample());
    check("midrst_no_frame", 128'(frame_valid), 128'(0));
    check("midrst_busy",     128'(busy),        128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
